// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module   : if_stage_pkg
// Brief    : Shared types and constants for the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package if_stage_pkg;

   typedef enum logic [1:0] {
      IF_ST_IDLE = 2'd0,
      IF_ST_REQ  = 2'd1,
      IF_ST_WAIT = 2'd2,
      IF_ST_KILL = 2'd3
   } if_state_e;

   localparam logic [31:0] INST_NOP      = 32'h0000_0013;
   localparam logic [31:0] PC_STEP       = 32'd4;
   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } if_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_skid_buf.sv
// ============================================================================
// Module   : if_skid_buf
// Brief    : One-entry {inst,pc} skid buffer with load, drain and flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_skid_buf
   import if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_drain,
   input  logic        i_flush,
   input  logic [31:0] i_inst,
   input  logic [31:0] i_pc,
   output logic        o_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc
);

   logic      r_valid;
   if_entry_t r_entry;

   // Flush outranks load so a redirect always leaves the buffer empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_entry <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid      <= 1'b1;
         r_entry.inst <= i_inst;
         r_entry.pc   <= i_pc;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_inst  = r_entry.inst;
   assign o_pc    = r_entry.pc;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch: PC, imem request FSM, decode output register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4
);

   if_state_e   r_state;
   logic [31:0] r_pc;
   logic [31:0] r_fetch_pc;
   logic        r_id_valid;
   logic [31:0] r_id_inst;
   logic [31:0] r_id_pc;
   logic [31:0] r_id_pc4;

   logic        w_skid_valid;
   logic [31:0] w_skid_inst;
   logic [31:0] w_skid_pc;
   logic        w_req_fire;
   logic        w_deliver;
   logic        w_out_free;
   logic        w_skid_load;
   logic        w_skid_drain;

   // Holding requests while the skid is full guarantees it has room for any response.
   assign imem_req_valid = (r_state == IF_ST_REQ) && !w_skid_valid;
   assign imem_addr      = r_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;
   assign w_deliver      = (r_state == IF_ST_WAIT) && imem_rsp_valid && !redirect_valid;
   assign w_out_free     = !r_id_valid || id_ready;
   assign w_skid_load    = w_deliver && !w_out_free;
   assign w_skid_drain   = w_out_free && w_skid_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IF_ST_IDLE;
         r_pc       <= RESET_PC;
         r_fetch_pc <= '0;
      end else if (redirect_valid) begin
         r_pc <= redirect_pc & PC_ALIGN_MASK;
         case (r_state)
            IF_ST_IDLE: r_state <= IF_ST_REQ;
            IF_ST_REQ:  r_state <= w_req_fire ? IF_ST_KILL : IF_ST_REQ;
            IF_ST_WAIT: r_state <= imem_rsp_valid ? IF_ST_REQ : IF_ST_KILL;
            IF_ST_KILL: r_state <= imem_rsp_valid ? IF_ST_REQ : IF_ST_KILL;
            default:    r_state <= IF_ST_IDLE;
         endcase
      end else begin
         case (r_state)
            IF_ST_IDLE: r_state <= IF_ST_REQ;
            IF_ST_REQ: begin
               if (w_req_fire) begin
                  r_fetch_pc <= r_pc;
                  r_pc       <= r_pc + PC_STEP;
                  r_state    <= IF_ST_WAIT;
               end
            end
            IF_ST_WAIT: if (imem_rsp_valid) r_state <= IF_ST_REQ;
            IF_ST_KILL: if (imem_rsp_valid) r_state <= IF_ST_REQ;
            default:    r_state <= IF_ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_id_valid <= 1'b0;
         r_id_inst  <= INST_NOP;
         r_id_pc    <= '0;
         r_id_pc4   <= '0;
      end else if (redirect_valid) begin
         r_id_valid <= 1'b0;
      end else if (w_out_free) begin
         if (w_skid_valid) begin
            r_id_valid <= 1'b1;
            r_id_inst  <= w_skid_inst;
            r_id_pc    <= w_skid_pc;
            r_id_pc4   <= w_skid_pc + PC_STEP;
         end else if (w_deliver) begin
            r_id_valid <= 1'b1;
            r_id_inst  <= imem_rsp_data;
            r_id_pc    <= r_fetch_pc;
            r_id_pc4   <= r_fetch_pc + PC_STEP;
         end else begin
            r_id_valid <= 1'b0;
         end
      end
   end

   if_skid_buf u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_skid_load),
      .i_drain (w_skid_drain),
      .i_flush (redirect_valid),
      .i_inst  (imem_rsp_data),
      .i_pc    (r_fetch_pc),
      .o_valid (w_skid_valid),
      .o_inst  (w_skid_inst),
      .o_pc    (w_skid_pc)
   );

   assign id_valid = r_id_valid;
   assign id_inst  = r_id_inst;
   assign id_pc    = r_id_pc;
   assign id_pc4   = r_id_pc4;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Brief    : Directed self-checking bench for if_stage with a latency-programmable imem.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

   localparam logic [31:0] K   = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_addr, imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid, id_ready;
   logic [31:0] id_inst, id_pc, id_pc4;

   logic        req_valid2, rsp_valid2, id_valid2;
   logic [31:0] addr2, rsp_data2, id_inst2, id_pc2, id_pc4_2;

   int          n_vec = 0;
   int          n_fail = 0;
   int          lat = 1;
   logic        pend;
   int          cnt;
   logic [31:0] pend_addr;
   int          hs_cnt = 0;
   logic [31:0] hs_last_pc = '0;

   logic [31:0] wrap_addr [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
   logic [31:0] wrap_pc4  [3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

   if_stage u_dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(req_valid2), .imem_req_ready(1'b1), .imem_addr(addr2),
      .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .id_valid(id_valid2), .id_ready(1'b1), .id_inst(id_inst2), .id_pc(id_pc2), .id_pc4(id_pc4_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Fixed-order imem with programmable latency (1 = response the cycle after acceptance).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_rsp_valid <= 1'b0;
         imem_rsp_data  <= '0;
         pend           <= 1'b0;
         cnt            <= 0;
         pend_addr      <= '0;
      end else begin
         imem_rsp_valid <= 1'b0;
         if (pend) begin
            if (cnt <= 1) begin
               imem_rsp_valid <= 1'b1;
               imem_rsp_data  <= pend_addr ^ K;
               pend           <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
         if (imem_req_valid && imem_req_ready) begin
            if (lat <= 1) begin
               imem_rsp_valid <= 1'b1;
               imem_rsp_data  <= imem_addr ^ K;
            end else begin
               pend      <= 1'b1;
               pend_addr <= imem_addr;
               cnt       <= lat - 1;
            end
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid2 <= 1'b0;
         rsp_data2  <= '0;
      end else begin
         rsp_valid2 <= req_valid2;
         rsp_data2  <= addr2 ^ K;
      end
   end

   always @(posedge clk) begin
      if (rst_n && id_valid && id_ready) begin
         hs_cnt     <= hs_cnt + 1;
         hs_last_pc <= id_pc;
      end
   end

   task automatic do_reset(input int latency);
      rst_n          = 1'b0;
      lat            = latency;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_id_valid(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (id_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; lat = 1; imem_req_ready = 1'b1; redirect_valid = 1'b0;
      redirect_pc = '0; id_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", id_valid); end
      n_vec++; if (id_inst !== NOP) begin n_fail++; $display("FAIL rst_inst: got %h exp %h", id_inst, NOP); end
      n_vec++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h exp 0", id_pc); end
      n_vec++; if (id_pc4 !== 32'h0) begin n_fail++; $display("FAIL rst_pc4: got %h exp 0", id_pc4); end
      n_vec++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", imem_req_valid); end
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++; $display("FAIL first_req: got v=%b a=%h exp v=1 a=0", imem_req_valid, imem_addr); end
   endtask

   task automatic test_stream;
      logic [31:0] exp_a, exp_p;
      bit prev, seen;
      int ndel;
      do_reset(1);
      exp_a = 0; exp_p = 0; prev = 0; seen = 0; ndel = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (imem_req_valid) begin
            n_vec++; if (imem_addr !== exp_a) begin n_fail++; $display("FAIL stream_addr: got %h exp %h", imem_addr, exp_a); end
            exp_a += 4;
         end
         if (id_valid) begin
            n_vec++; if (id_pc !== exp_p || id_pc4 !== exp_p + 4 || id_inst !== (exp_p ^ K)) begin
               n_fail++; $display("FAIL stream_out: got pc=%h pc4=%h inst=%h exp pc=%h", id_pc, id_pc4, id_inst, exp_p); end
            exp_p += 4;
            ndel++;
         end
         if (seen) begin
            n_vec++; if (id_valid === prev) begin n_fail++; $display("FAIL stream_cadence: got %b exp %b", id_valid, !prev); end
         end
         seen = seen | id_valid;
         prev = id_valid;
      end
      n_vec++; if (ndel != 11) begin n_fail++; $display("FAIL stream_count: got %0d exp 11", ndel); end
   endtask

   task automatic test_backpressure;
      bit ok;
      int nreq;
      do_reset(1);
      id_ready = 1'b0;
      wait_id_valid(20, ok);
      n_vec++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got none exp id_valid"); end
      nreq = 0;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         if (imem_req_valid) nreq++;
         n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
            n_fail++; $display("FAIL bp_hold: got v=%b pc=%h exp v=1 pc=0", id_valid, id_pc); end
      end
      n_vec++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got %b exp 0", imem_req_valid); end
      n_vec++; if (nreq != 1) begin n_fail++; $display("FAIL bp_nreq: got %0d exp 1", nreq); end
      @(negedge clk);
      id_ready = 1'b1;
      n_vec++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL bp_rel0: got %h exp 0", id_pc); end
      @(negedge clk);
      n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_inst !== (32'h4 ^ K)) begin
         n_fail++; $display("FAIL bp_rel1: got v=%b pc=%h inst=%h exp v=1 pc=4", id_valid, id_pc, id_inst); end
      n_vec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin
         n_fail++; $display("FAIL bp_resume: got v=%b a=%h exp v=1 a=8", imem_req_valid, imem_addr); end
      @(negedge clk);
      wait_id_valid(10, ok);
      n_vec++; if (!ok || id_pc !== 32'h8) begin n_fail++; $display("FAIL bp_next: got ok=%b pc=%h exp pc=8", ok, id_pc); end
   endtask

   task automatic test_redirect_wait;
      bit ok, got_req;
      do_reset(3);
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         ok = imem_req_valid;
      end
      n_vec++; if (!ok) begin n_fail++; $display("FAIL rw_noreq: got none exp request"); end
      @(negedge clk);
      n_vec++; if (imem_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_pre: got rsp=%b exp 0", imem_rsp_valid); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_vec++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rw_flush: got %b exp 0", id_valid); end
      got_req = 0; ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         if (imem_req_valid && !got_req) begin
            got_req = 1;
            n_vec++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rw_addr: got %h exp 00000100", imem_addr); end
         end
         if (id_valid) begin
            ok = 1;
            n_vec++; if (id_pc !== 32'h100 || id_pc4 !== 32'h104 || id_inst !== (32'h100 ^ K)) begin
               n_fail++; $display("FAIL rw_out: got pc=%h pc4=%h inst=%h exp pc=100", id_pc, id_pc4, id_inst); end
         end
         if (!ok) @(negedge clk);
      end
      n_vec++; if (!ok || !got_req) begin n_fail++; $display("FAIL rw_timeout: got ok=%b req=%b exp 1/1", ok, got_req); end
   endtask

   task automatic test_redirect_rsp_hs;
      bit ok;
      int hs0;
      do_reset(1);
      id_ready = 1'b0;
      wait_id_valid(20, ok);
      @(negedge clk);
      n_vec++; if (!ok || imem_rsp_valid !== 1'b1 || id_valid !== 1'b1 || id_pc !== 32'h0) begin
         n_fail++; $display("FAIL rh_pre: got rsp=%b v=%b pc=%h exp rsp=1 v=1 pc=0", imem_rsp_valid, id_valid, id_pc); end
      hs0 = hs_cnt;
      id_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_vec++; if (hs_cnt != hs0 + 1 || hs_last_pc !== 32'h0) begin
         n_fail++; $display("FAIL rh_hs: got cnt=+%0d pc=%h exp +1 pc=0", hs_cnt - hs0, hs_last_pc); end
      n_vec++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rh_flush: got %b exp 0", id_valid); end
      n_vec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin
         n_fail++; $display("FAIL rh_req: got v=%b a=%h exp v=1 a=200", imem_req_valid, imem_addr); end
      wait_id_valid(10, ok);
      n_vec++; if (!ok || id_pc !== 32'h200) begin n_fail++; $display("FAIL rh_next: got ok=%b pc=%h exp pc=200", ok, id_pc); end
   endtask

   task automatic test_wrap;
      int j, k;
      do_reset(1);
      j = 0; k = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (req_valid2 && j < 3) begin
            n_vec++; if (addr2 !== wrap_addr[j]) begin n_fail++; $display("FAIL wrap_addr: got %h exp %h", addr2, wrap_addr[j]); end
            j++;
         end
         if (id_valid2 && k < 3) begin
            n_vec++; if (id_pc2 !== wrap_addr[k] || id_pc4_2 !== wrap_pc4[k]) begin
               n_fail++; $display("FAIL wrap_out: got pc=%h pc4=%h exp pc=%h pc4=%h", id_pc2, id_pc4_2, wrap_addr[k], wrap_pc4[k]); end
            k++;
         end
      end
      n_vec++; if (j != 3 || k != 3) begin n_fail++; $display("FAIL wrap_count: got %0d/%0d exp 3/3", j, k); end
   endtask

   task automatic test_mid_reset;
      bit ok;
      do_reset(3);
      id_ready = 1'b0;
      wait_id_valid(20, ok);
      @(negedge clk);
      n_vec++; if (!ok || id_valid !== 1'b1 || id_inst !== K || id_pc4 !== 32'h4) begin
         n_fail++; $display("FAIL mr_pre: got v=%b inst=%h pc4=%h exp v=1 inst=%h pc4=4", id_valid, id_inst, id_pc4, K); end
      #1 rst_n = 1'b0;
      #1;
      n_vec++; if (id_valid !== 1'b0 || id_inst !== NOP || id_pc !== 32'h0 || id_pc4 !== 32'h0 || imem_req_valid !== 1'b0) begin
         n_fail++; $display("FAIL mr_async: got v=%b inst=%h pc=%h pc4=%h req=%b exp reset values",
                            id_valid, id_inst, id_pc, id_pc4, imem_req_valid); end
      @(negedge clk);
      rst_n    = 1'b1;
      id_ready = 1'b1;
      @(negedge clk);
      n_vec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++; $display("FAIL mr_req: got v=%b a=%h exp v=1 a=0", imem_req_valid, imem_addr); end
      wait_id_valid(20, ok);
      n_vec++; if (!ok || id_pc !== 32'h0 || id_inst !== K) begin
         n_fail++; $display("FAIL mr_out: got ok=%b pc=%h inst=%h exp pc=0", ok, id_pc, id_inst); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_redirect_rsp_hs();
      test_wrap();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
